uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of byte requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, byte width matching the UART transmitter.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Port: clk  input  1  rising-edge clock, the single clock of the block.
REQ-005 Port: rst  input  1  asynchronous active-high reset.
REQ-006 Port: req_valid  input  NUM_REQ  per-requester byte-available flag.
REQ-007 Port: req_data  input  NUM_REQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 Port: req_last  input  NUM_REQ  per-requester end-of-message flag; present only with UART_ARB_LOCK_EN.
REQ-009 Port: req_ready  output  NUM_REQ  one-hot acceptance strobe; transfer when req_valid[i] and req_ready[i] are both high.
REQ-010 Port: tx_valid  output  1  byte offer to the UART transmitter.
REQ-011 Port: tx_data  output  DATA_W  byte to the UART transmitter.
REQ-012 Port: tx_ready  input  1  transmitter idle/accept flag from the UART transmitter.
REQ-013 Port: grant  output  NUM_REQ  one-hot index of the requester whose byte is in flight; zero when none.
REQ-014 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, SEND and GAP.
REQ-016 IDLE: when tx_ready=1 and at least one eligible req_valid is high, SHALL assert req_ready for exactly one winner in the same cycle (combinational), latch its byte into tx_data, set grant, and go to SEND.
REQ-017 IDLE with tx_ready=0 or no eligible request: req_ready SHALL be all zero and state SHALL remain IDLE.
REQ-018 Arbitration SHALL be round-robin: search order starts at pointer ptr and wraps modulo NUM_REQ; after a grant to index i, ptr SHALL become (i+1) mod NUM_REQ.
REQ-019 SEND: tx_valid SHALL be 1 with tx_data stable; on a cycle with tx_ready=1 the byte is accepted and the state SHALL go to GAP.
REQ-020 GAP: tx_valid SHALL be 0, tx_ready SHALL be ignored for exactly one cycle, grant SHALL clear, state SHALL return to IDLE.
REQ-021 Latency: a byte accepted from a requester in cycle N SHALL present tx_valid=1 in cycle N+1; minimum spacing between two req_ready strobes is 3 cycles plus the transmitter's busy time.
REQ-022 req_ready SHALL never be asserted outside IDLE and never to more than one requester.
REQ-023 A requester deasserting req_valid before being granted SHALL lose no state; its turn is simply skipped.
REQ-024 tx_data SHALL hold its last value outside SEND; tx_valid SHALL be 0 outside SEND.

Reset
REQ-025 Asserting rst SHALL immediately force state=IDLE, ptr=0, tx_valid=0, tx_data=0, grant=0, busy=0, req_ready=0, lock cleared.
REQ-026 Reset in SEND SHALL drop the pending byte without retry; the requester is not re-notified.
REQ-027 The first arbitration SHALL occur on the first rising clk edge after rst deasserts.

Configuration
REQ-028 Macro UART_ARB_LOCK_EN SHALL compile in message locking and the req_last port.
REQ-029 With UART_ARB_LOCK_EN: accepting a byte with req_last=0 SHALL lock to that requester; only it is eligible until a byte with req_last=1 is accepted, which clears the lock and advances ptr normally.
REQ-030 With UART_ARB_LOCK_EN: a locked requester holding req_valid=0 SHALL stall the arbiter in IDLE indefinitely; no timeout.
REQ-031 Without UART_ARB_LOCK_EN: every byte SHALL be arbitrated independently and req_last SHALL not exist.

Verification
REQ-032 Single request: req_valid=4'b0001, data 0x41, tx_ready=1 -> req_ready=4'b0001 in cycle N, tx_valid=1 with tx_data=0x41 in N+1, grant=4'b0001.
REQ-033 All requesters valid continuously, tx_ready pulsing -> grants in order 0,1,2,3,0; each requester gets one byte per four.
REQ-034 tx_ready held 0 for 20 cycles during SEND -> tx_valid and tx_data stay constant; no req_ready strobes.
REQ-035 rst asserted mid-SEND -> tx_valid=0 and grant=0 within the same cycle; after release, requester 0 wins first.
REQ-036 UART_ARB_LOCK_EN, requester 2 sends 3 bytes (last on third) while requester 0 valid -> bytes 2,2,2 then 0.
REQ-037 Requester 1 deasserts req_valid while requester 3 is granted -> next grant goes to next valid index after 3, no spurious req_ready[1].

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that funnels bytes from NUM_REQ requesters
// into a single UART transmitter through an IDLE -> SEND -> GAP handshake.
// Optional message locking (adds the req_last port) is compiled in by defining
// the macro UART_ARB_LOCK_EN; the default build arbitrates every byte independently.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_last,
`endif
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_valid,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t              state;
    logic [PTR_W-1:0]    ptr;
    logic [NUM_REQ-1:0]  eligible;
    logic                win_found;
    logic [PTR_W-1:0]    win_idx;
    logic [PTR_W-1:0]    next_ptr;
    logic [DATA_W-1:0]   win_data;
    logic [NUM_REQ-1:0]  win_onehot;
    logic                take;

    // Converts a requester index into its one-hot mask.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [NUM_REQ-1:0] mask;
        mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == idx) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

`ifdef UART_ARB_LOCK_EN
    logic             lock_active;
    logic [PTR_W-1:0] lock_idx;
    logic             win_last;

    // While a message is locked only its owner may compete for the transmitter.
    always_comb begin
        eligible = req_valid;
        if (lock_active) begin
            eligible = req_valid & onehot(lock_idx);
        end
    end

    // Picks out the winner's end-of-message flag.
    always_comb begin
        win_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == win_idx) begin
                win_last = req_last[i];
            end
        end
    end

    // Lock to the winner on a non-final byte, release on the final one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_active <= 1'b0;
            lock_idx    <= '0;
        end else if (take) begin
            lock_active <= !win_last;
            lock_idx    <= win_idx;
        end
    end
`else
    assign eligible = req_valid;
`endif

    // Round-robin search: first eligible requester starting at ptr, wrapping modulo NUM_REQ.
    always_comb begin
        logic [PTR_W:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (PTR_W+1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!win_found && eligible[cand[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // Selects the winner's byte from the packed request bus.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == win_idx) begin
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign win_onehot = onehot(win_idx);
    assign next_ptr   = (win_idx == LAST_IDX) ? '0 : win_idx + PTR_W'(1);

    // The acceptance strobe is combinational and only ever fires in IDLE, out of reset.
    assign take      = (state == IDLE) && tx_ready && win_found && !rst;
    assign req_ready = take ? win_onehot : '0;
    assign busy      = (state != IDLE);

    // Main handshake FSM: latch a byte in IDLE, offer it in SEND, pause one cycle in GAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            grant    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        state    <= SEND;
                        ptr      <= next_ptr;
                        tx_valid <= 1'b1;
                        tx_data  <= win_data;
                        grant    <= win_onehot;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        state    <= GAP;
                        tx_valid <= 1'b0;
                        grant    <= '0;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    grant    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table-driven bench for uart_tx_arbiter with a byte scoreboard.
// The lock sequence is included only when UART_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_valid;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_ready;
    logic [NUM_REQ-1:0]        grant;
    logic                      busy;
`ifdef UART_ARB_LOCK_EN
    logic [NUM_REQ-1:0]        req_last;
`endif

    typedef struct {
        logic [3:0] mask;
        logic       txr;
        logic [3:0] exp_req;
        int         hold;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [3:0] grant;
    } exp_t;

    vec_t vecs[15];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   seq      = 0;

    uart_tx_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
`ifdef UART_ARB_LOCK_EN
        .req_last  (req_last),
`endif
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant     (grant),
        .busy      (busy)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "[TB] watchdog expired");
    end

    // Byte offered by requester i for transaction number s.
    function automatic logic [7:0] byteFor(input int s, input int i);
        return 8'h41 + 8'(s * 4 + i);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] mask, input logic txr);
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*DATA_W +: DATA_W] = byteFor(seq, i);
        end
        req_valid = mask;
        tx_ready  = txr;
    endtask

    task automatic pushExpected(input logic [3:0] oh);
        exp_t e;
        int   idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = i;
        end
        e.data  = byteFor(seq, idx);
        e.grant = oh;
        sb.push_back(e);
    endtask

    task automatic popCompare(input string name, output logic [7:0] d);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL %s: tx_valid seen with empty scoreboard, tx_data=0x%0h", name, tx_data);
            d = 'x;
        end else begin
            e = sb.pop_front();
            checkOutput({name, "_data"}, tx_data, e.data);
            checkOutput({name, "_grant"}, grant, e.grant);
            d = e.data;
        end
    endtask

    // Runs one table record; entered and left #1 after a rising edge with the DUT in IDLE.
    task automatic runVector(input vec_t v, input int k);
        logic [7:0] held;
        applyStimulus(v.mask, v.txr);
        @(negedge clk);
        checkOutput($sformatf("v%0d_req_ready", k), req_ready, v.exp_req);
        if (v.exp_req != 4'b0) pushExpected(v.exp_req);
        @(posedge clk); #1;
        if (v.exp_req == 4'b0) begin
            @(negedge clk);
            checkOutput($sformatf("v%0d_idle_busy", k), busy, 0);
            checkOutput($sformatf("v%0d_idle_tx_valid", k), tx_valid, 0);
            @(posedge clk); #1;
        end else begin
            tx_ready = (v.hold == 0);
            @(negedge clk);
            checkOutput($sformatf("v%0d_tx_valid", k), tx_valid, 1);
            popCompare($sformatf("v%0d", k), held);
            for (int h = 0; h < v.hold; h++) begin
                @(posedge clk); #1;
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_data[i*DATA_W +: DATA_W] = byteFor(seq + 50 + h, i);
                end
                if (h == v.hold - 1) tx_ready = 1'b1;
                @(negedge clk);
                checkOutput($sformatf("v%0d_hold%0d_tx_valid", k, h), tx_valid, 1);
                checkOutput($sformatf("v%0d_hold%0d_tx_data", k, h), tx_data, held);
                checkOutput($sformatf("v%0d_hold%0d_req_ready", k, h), req_ready, 0);
            end
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput($sformatf("v%0d_gap_tx_valid", k), tx_valid, 0);
            checkOutput($sformatf("v%0d_gap_grant", k), grant, 0);
            checkOutput($sformatf("v%0d_gap_req_ready", k), req_ready, 0);
            checkOutput($sformatf("v%0d_gap_tx_data", k), tx_data, held);
            @(posedge clk); #1;
        end
        seq++;
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        req_valid = '0;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Main sequence: reset, vector table, reset mid-SEND, continuous streaming, optional locking.
    initial begin
        logic [7:0] dummy;
        logic [3:0] exp_rr;

        vecs[0]  = '{4'b0001, 1'b1, 4'b0001, 0};
        vecs[1]  = '{4'b0000, 1'b1, 4'b0000, 0};
        vecs[2]  = '{4'b1111, 1'b0, 4'b0000, 0};
        vecs[3]  = '{4'b1111, 1'b1, 4'b0010, 0};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0100, 20};
        vecs[5]  = '{4'b1111, 1'b1, 4'b1000, 2};
        vecs[6]  = '{4'b1111, 1'b1, 4'b0001, 0};
        vecs[7]  = '{4'b0001, 1'b1, 4'b0001, 0};
        vecs[8]  = '{4'b1001, 1'b1, 4'b1000, 0};
        vecs[9]  = '{4'b0110, 1'b1, 4'b0010, 0};
        vecs[10] = '{4'b0011, 1'b1, 4'b0001, 0};
        vecs[11] = '{4'b1100, 1'b1, 4'b0100, 0};
        vecs[12] = '{4'b1010, 1'b1, 4'b1000, 3};
        vecs[13] = '{4'b0100, 1'b1, 4'b0100, 0};
        vecs[14] = '{4'b0011, 1'b1, 4'b0001, 0};

        rst       = 1'b1;
        req_valid = '1;
        req_data  = '0;
        tx_ready  = 1'b1;
`ifdef UART_ARB_LOCK_EN
        req_last  = '1;
`endif
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_tx_valid", tx_valid, 0);
        checkOutput("reset_tx_data", tx_data, 0);
        checkOutput("reset_grant", grant, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_req_ready", req_ready, 0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 15; k++) begin
            runVector(vecs[k], k);
        end

        // Reset while a byte is being offered; the byte is dropped.
        applyStimulus(4'b0100, 1'b1);
        @(negedge clk);
        checkOutput("rstsend_req_ready", req_ready, 4'b0100);
        pushExpected(4'b0100);
        @(posedge clk); #1;
        tx_ready = 1'b0;
        @(negedge clk);
        checkOutput("rstsend_tx_valid", tx_valid, 1);
        popCompare("rstsend", dummy);
        @(posedge clk); #2;
        tx_ready = 1'b1;
        rst      = 1'b1;
        #1;
        checkOutput("rstsend_async_tx_valid", tx_valid, 0);
        checkOutput("rstsend_async_grant", grant, 0);
        checkOutput("rstsend_async_busy", busy, 0);
        checkOutput("rstsend_async_req_ready", req_ready, 0);
        checkOutput("rstsend_async_tx_data", tx_data, 0);
        seq++;

        // Continuous streaming after release: strobes every 3 cycles in order 0,1,2,3,0.
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(4'b1111, 1'b1);
        #2;
        for (int c = 0; c < 13; c++) begin
            if (c > 0) @(negedge clk);
            exp_rr = (c % 3 == 0) ? 4'(1 << ((c / 3) % 4)) : 4'b0000;
            checkOutput($sformatf("stream%0d_req_ready", c), req_ready, exp_rr);
            checkOutput($sformatf("stream%0d_tx_valid", c), tx_valid, (c % 3 == 1) ? 1 : 0);
            if (tx_valid) popCompare($sformatf("stream%0d", c), dummy);
            if (exp_rr != 4'b0) pushExpected(exp_rr);
        end
        seq++;

`ifdef UART_ARB_LOCK_EN
        // Requester 2 holds the transmitter for a three-byte message, stalling when idle.
        doReset();
        req_last = 4'b0000;
        runVector('{4'b0100, 1'b1, 4'b0100, 0}, 100);
        runVector('{4'b0001, 1'b1, 4'b0000, 0}, 101);
        runVector('{4'b0101, 1'b1, 4'b0100, 0}, 102);
        req_last = 4'b0100;
        runVector('{4'b0101, 1'b1, 4'b0100, 0}, 103);
        req_last = 4'b1111;
        runVector('{4'b0101, 1'b1, 4'b0001, 0}, 104);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
